issue_queue: RTL



---
 rtl/tomasulo_pkg.sv | 42 ++++
 rtl/issue_fifo.sv | 57 +++++
 rtl/issue_queue.sv | 101 ++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: instruction layout, opcodes and the
// opcode classifier used by the issue queue.
package tomasulo_pkg;

  localparam int unsigned INST_W    = 16;

  // Instruction field positions
  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 13;
  localparam int unsigned DEST_MSB  = 12;
  localparam int unsigned DEST_LSB  = 10;
  localparam int unsigned SRC1_MSB  = 9;
  localparam int unsigned SRC1_LSB  = 7;
  localparam int unsigned SRC2_MSB  = 6;
  localparam int unsigned SRC2_LSB  = 4;
  localparam int unsigned SPARE_MSB = 3;
  localparam int unsigned SPARE_LSB = 0;

  // Legal opcodes; anything with op[2] set is illegal
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_MUL,
    CLS_ILL
  } op_class_t;

  // Map an opcode onto the reservation station class that executes it
  function automatic op_class_t classify(input logic [2:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB: cls = CLS_ADD;
      OP_MUL, OP_DIV: cls = CLS_MUL;
      default:        cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Instruction FIFO for the issue queue: storage, wrapping pointers,
// occupancy count and empty/full flags. Head data is read combinationally.
module issue_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1,
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Storage write at the tail; contents need no reset
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: buffers fetched instructions, classifies the head
// and dispatches it to the adder or multiplier reservation station.
// Optional feature macro: ISSUE_STALL_CNT_EN adds a saturating stallCount.
module issue_queue
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [INST_W-1:0] instIn,
  input  logic              instInValid,
  output logic              instInReady,
  input  logic              adderFull,
  input  logic              multFull,
  output logic [INST_W-1:0] instruction,
  output logic              Adderin,
  output logic              Multin,
  output logic              invalidOp,
`ifdef ISSUE_STALL_CNT_EN
  output logic [15:0]       stallCount,
`endif
  output logic [CNT_W-1:0]  count
);

  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [INST_W-1:0] head;
  op_class_t         head_cls;
  logic              add_go;
  logic              mul_go;
  logic              ill_go;

  assign instInReady = !full;
  assign push        = instInValid && !full;

  issue_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .WIDTH(INST_W)
  ) u_fifo (
    .Clock(Clock),
    .Reset(Reset),
    .push (push),
    .pop  (pop),
    .wdata(instIn),
    .rdata(head),
    .empty(empty),
    .full (full),
    .count(count)
  );

  // Head dispatch decision. The per-class holdoff is exactly the previous
  // cycle's dispatch pulse, so Adderin/Multin double as the holdoff flags.
  always_comb begin
    head_cls = classify(head[OP_MSB:OP_LSB]);
    add_go   = 1'b0;
    mul_go   = 1'b0;
    ill_go   = 1'b0;
    if (!empty) begin
      case (head_cls)
        CLS_ADD: add_go = !adderFull && !Adderin;
        CLS_MUL: mul_go = !multFull && !Multin;
        default: ill_go = 1'b1;
      endcase
    end
    pop = add_go || mul_go || ill_go;
  end

  // Registered dispatch pulses and the instruction bus to the stations
  always_ff @(posedge Clock) begin
    if (Reset) begin
      instruction <= '0;
      Adderin     <= 1'b0;
      Multin      <= 1'b0;
      invalidOp   <= 1'b0;
    end else begin
      Adderin   <= add_go;
      Multin    <= mul_go;
      invalidOp <= ill_go;
      if (add_go || mul_go) begin
        instruction <= head;
      end
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  // Count cycles where a queued head fails to leave, saturating at all-ones
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stallCount <= '0;
    end else if (!empty && !pop && (stallCount != '1)) begin
      stallCount <= stallCount + 16'd1;
    end
  end
`endif

endmodule
